// File: rtl/can_error_frame.sv
// can_error_frame: drives active/passive CAN error flags, waits out flag
// superposition and the error delimiter, and sequences bus-off recovery by
// counting occurrences of consecutive recessive bits.
module can_error_frame #(
   parameter int unsigned FLAG_LEN  = 6,
   parameter int unsigned DELIM_LEN = 8,
   parameter int unsigned RECOV_RUN = 11,
   parameter int unsigned RECOV_OCC = 128
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_point,
   input  logic rx_bit,
   input  logic bit_error,
   input  logic stuff_error,
   input  logic form_error,
   input  logic ack_error,
   input  logic crc_error,
   input  logic error_passive,
   input  logic bus_off,
   output logic tx_bit,
   output logic err_frame_active,
   output logic flag_passive,
   output logic dominant_after_flag,
   output logic err_frame_done,
   output logic bus_off_recovering,
   output logic recovery_done
);

   typedef enum logic [2:0] {
      IDLE,
      FLAG,
      WAIT_REC,
      DELIM,
      BUS_OFF
   } state_t;

   // Terminal counts, expressed as "last value before the terminal event"
   localparam logic [3:0] FLAG_LAST  = 4'(FLAG_LEN - 1);
   localparam logic [3:0] DELIM_LAST = 4'(DELIM_LEN - 1);
   localparam logic [3:0] RUN_LAST   = 4'(RECOV_RUN - 1);
   localparam logic [7:0] OCC_LAST   = 8'(RECOV_OCC - 1);

   state_t     state;
   logic [3:0] bit_cnt;
   logic [3:0] run_cnt;
   logic [7:0] occ_cnt;
   logic       dom_seen;
   logic       err_trig;

   assign err_trig           = bit_error | stuff_error | form_error | ack_error | crc_error;
   assign err_frame_active   = (state == FLAG) || (state == WAIT_REC) || (state == DELIM);
   assign bus_off_recovering = (state == BUS_OFF);

   // Single sequencer: bus-off entry has priority, otherwise each state
   // advances only on sample points (except the IDLE trigger, which is
   // taken on any cycle so the flag starts at the very next bit).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state               <= IDLE;
         tx_bit              <= 1'b1;
         flag_passive        <= 1'b0;
         dominant_after_flag <= 1'b0;
         err_frame_done      <= 1'b0;
         recovery_done       <= 1'b0;
         bit_cnt             <= 4'd0;
         run_cnt             <= 4'd0;
         occ_cnt             <= 8'd0;
         dom_seen            <= 1'b0;
      end else begin
         dominant_after_flag <= 1'b0;
         err_frame_done      <= 1'b0;
         recovery_done       <= 1'b0;
         if (bus_off && (state != BUS_OFF)) begin
            state    <= BUS_OFF;
            tx_bit   <= 1'b1;
            bit_cnt  <= 4'd0;
            run_cnt  <= 4'd0;
            occ_cnt  <= 8'd0;
            dom_seen <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (err_trig) begin
                     state        <= FLAG;
                     flag_passive <= error_passive;
                     tx_bit       <= error_passive;
                     bit_cnt      <= 4'd0;
                     dom_seen     <= 1'b0;
                  end
               end
               FLAG: begin
                  if (sample_point) begin
                     if (bit_cnt >= FLAG_LAST) begin
                        state   <= WAIT_REC;
                        tx_bit  <= 1'b1;
                        bit_cnt <= 4'd0;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               WAIT_REC: begin
                  if (sample_point) begin
                     if (!rx_bit) begin
                        if (!flag_passive && !dom_seen) begin
                           dominant_after_flag <= 1'b1;
                           dom_seen            <= 1'b1;
                        end
                     end else begin
                        state   <= DELIM;
                        bit_cnt <= 4'd1;
                     end
                  end
               end
               DELIM: begin
                  if (sample_point) begin
                     if (rx_bit) begin
                        if (bit_cnt >= DELIM_LAST) begin
                           state          <= IDLE;
                           err_frame_done <= 1'b1;
                           bit_cnt        <= 4'd0;
                        end else begin
                           bit_cnt <= bit_cnt + 4'd1;
                        end
                     end else begin
                        state        <= FLAG;
                        flag_passive <= error_passive;
                        tx_bit       <= error_passive;
                        bit_cnt      <= 4'd0;
                        dom_seen     <= 1'b0;
                     end
                  end
               end
               BUS_OFF: begin
                  if (sample_point) begin
                     if (rx_bit) begin
                        if (run_cnt >= RUN_LAST) begin
                           run_cnt <= 4'd0;
                           if (occ_cnt >= OCC_LAST) begin
                              occ_cnt       <= 8'd0;
                              recovery_done <= 1'b1;
                              state         <= IDLE;
                           end else begin
                              occ_cnt <= occ_cnt + 8'd1;
                           end
                        end else begin
                           run_cnt <= run_cnt + 4'd1;
                        end
                     end else begin
                        run_cnt <= 4'd0;
                     end
                  end
               end
               default: begin
                  state  <= IDLE;
                  tx_bit <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
